// File: rtl/vga_reg_pkg.sv
// Shared types for the display register-write initiator.
// Bus widths match the sprite/score peripheral's write port.
package vga_reg_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } reg_wr_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } wr_state_e;

endpackage

// File: rtl/vga_reg_writer_if.sv
// Update stream from game logic into the register writer.
// The game side is the master; the writer is the slave.
interface vga_reg_writer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_address;
    logic [DATA_W-1:0] in_writedata;
    logic              in_last;

    modport master (
        output in_valid,
        output in_address,
        output in_writedata,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_address,
        input  in_writedata,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/reg_wr_fifo.sv
// Synchronous FIFO of register-write entries.
// Head entry is visible combinationally on rdata.
module reg_wr_fifo
    import vga_reg_pkg::*;
#(
    parameter type T     = reg_wr_t,
    parameter int  DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  T              wdata,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    // Power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_reg_writer.sv
// Buffers register updates as frame-atomic batches and replays
// them on the display write bus only during vertical blank.
module vga_reg_writer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = vga_reg_pkg::ADDR_W,
    parameter int DATA_W = vga_reg_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    vga_reg_writer_if.slave   up,
    input  logic              vblank,
    output logic              chipselect,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              forced_commit
);
    import vga_reg_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    wr_state_e     state, state_n;
    entry_t        wr_e, head;
    logic          push, pop, full, empty;
    logic          force_last, inc, dec;
    logic [CW-1:0] count, batches, batches_n;

    assign up.in_ready = !full;
    assign push        = up.in_valid && !full;
    // Last free slot always closes a batch so a full FIFO can drain.
    assign force_last  = count == CW'(DEPTH - 1);
    assign wr_e = '{last: up.in_last | force_last,
                    addr: up.in_address,
                    data: up.in_writedata};

    reg_wr_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_e),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        pop     = 1'b0;
        state_n = state;
        unique case (state)
            IDLE:  pop = vblank && batches != '0 && !empty;
            DRAIN: pop = !empty;
        endcase
        inc       = push && wr_e.last;
        dec       = pop && head.last;
        batches_n = batches;
        unique case (1'b1)
            inc && !dec: batches_n = batches + 1'b1;
            dec && !inc: batches_n = batches - 1'b1;
            default:     batches_n = batches;
        endcase
        // A started batch finishes regardless of vblank.
        if (pop)
            state_n = (head.last && !(vblank && batches_n != '0))
                      ? IDLE : DRAIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            batches       <= '0;
            chipselect    <= 1'b0;
            write         <= 1'b0;
            busy          <= 1'b0;
            address       <= '0;
            writedata     <= '0;
            forced_commit <= 1'b0;
        end else begin
            state         <= state_n;
            batches       <= batches_n;
            chipselect    <= pop;
            write         <= pop;
            busy          <= pop;
            forced_commit <= push && force_last && !up.in_last;
            if (pop) begin
                address   <= head.addr;
                writedata <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_vga_reg_writer.sv
// Directed and randomized checks of vga_reg_writer against a
// queue model of committed and pending register updates.
module tb_vga_reg_writer;
    import vga_reg_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          vblank;
    logic          chipselect, write, busy, forced_commit;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;

    always #5 clk = ~clk;

    vga_reg_writer_if #(.ADDR_W(AW), .DATA_W(DW)) up ();

    vga_reg_writer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .up            (up.slave),
        .vblank        (vblank),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .busy          (busy),
        .forced_commit (forced_commit)
    );

    typedef struct {
        logic          last;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // pend: uncommitted tail; exp_q: committed, awaiting replay
    ent_t pend[$];
    ent_t exp_q[$];
    int   wr_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   nwr    = 0;
    int   nbusy  = 0;
    int   cyc    = 0;
    logic prev_wr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        ent_t e;
        #1;
        cyc++;
        if (busy === 1'b1)
            nbusy++;
        if (write === 1'b1) begin
            nwr++;
            wr_cyc.push_back(cyc);
            if (!prev_wr)
                chk("burst_vblank", vblank, 1);
            chk("chipselect", chipselect, 1);
            chk("committed_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("address", address, e.a);
                chk("writedata", writedata, e.d);
            end
        end
        prev_wr = (write === 1'b1);
    end

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic l);
        int   occ;
        logic forced;
        logic exp_fc;
        @(negedge clk);
        occ = pend.size() + exp_q.size();
        chk("in_ready", up.in_ready, occ < DEPTH);
        forced          = (occ == DEPTH - 1);
        up.in_valid     = 1'b1;
        up.in_address   = a;
        up.in_writedata = d;
        up.in_last      = l;
        @(posedge clk);
        if (occ < DEPTH) begin
            pend.push_back('{l | forced, a, d});
            if (l | forced)
                while (pend.size() > 0)
                    exp_q.push_back(pend.pop_front());
        end
        exp_fc = (occ < DEPTH) && forced && !l;
        #1;
        chk("forced_commit", forced_commit, exp_fc);
        up.in_valid = 1'b0;
    endtask

    task automatic push_rand(input logic l);
        push(AW'($urandom), $urandom, l);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_nwr(input int target, input int bound);
        int k = 0;
        while (nwr < target && k < bound) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("wait_writes", nwr >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        reset           = 1'b1;
        vblank          = 1'b0;
        up.in_valid     = 1'b0;
        up.in_address   = '0;
        up.in_writedata = '0;
        up.in_last      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", write, 0);
        chk("rst_cs", chipselect, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fc", forced_commit, 0);
        chk("rst_addr", address, 0);
        chk("rst_data", writedata, 0);
        chk("rst_ready", up.in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // batch held until vblank, then two consecutive writes
        base = nwr;
        wr_cyc.delete();
        push(0, 100, 0);
        push(1, 80, 1);
        idle(5);
        chk("t1_hold", nwr, base);
        vblank = 1'b1;
        wait_nwr(base + 2, 10);
        idle(3);
        chk("t1_count", nwr, base + 2);
        chk("t1_consec", wr_cyc[1] - wr_cyc[0], 1);
        vblank = 1'b0;

        // uncommitted entries never replay
        base = nwr;
        vblank = 1'b1;
        repeat (3) push_rand(0);
        idle(5);
        chk("t2_uncommitted", nwr, base);
        push_rand(1);
        wait_nwr(base + 4, 10);
        idle(2);
        chk("t2_count", nwr, base + 4);
        vblank = 1'b0;

        // filling the FIFO forces a commit
        base = nwr;
        idle(1);
        repeat (DEPTH) push_rand(0);
        @(negedge clk);
        chk("t3_full", up.in_ready, 0);
        push_rand(1);
        idle(1);
        vblank = 1'b1;
        wait_nwr(base + DEPTH, 20);
        idle(3);
        chk("t3_count", nwr, base + DEPTH);
        vblank = 1'b0;

        // vblank falls mid-batch: batch completes, next one waits
        base = nwr;
        repeat (4) push_rand(0);
        push_rand(1);
        push_rand(0);
        push_rand(1);
        @(negedge clk);
        vblank = 1'b1;
        wait_nwr(base + 2, 10);
        @(negedge clk);
        vblank = 1'b0;
        idle(10);
        chk("t4_first", nwr, base + 5);
        vblank = 1'b1;
        wait_nwr(base + 7, 10);
        idle(2);
        chk("t4_second", nwr, base + 7);
        vblank = 1'b0;

        // reset mid-drain discards the rest of the batch
        base = nwr;
        repeat (4) push_rand(0);
        push_rand(1);
        @(negedge clk);
        vblank = 1'b1;
        wait_nwr(base + 2, 10);
        reset = 1'b1;
        #1;
        chk("t5_write", write, 0);
        chk("t5_cs", chipselect, 0);
        chk("t5_busy", busy, 0);
        pend.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready", up.in_ready, 1);
        idle(8);
        chk("t5_no_stale", nwr, base + 2);
        vblank = 1'b0;

        // back-to-back batches: no gap, busy for exactly 4 cycles
        base = nwr;
        push_rand(0);
        push_rand(1);
        push_rand(0);
        push_rand(1);
        @(negedge clk);
        nbusy = 0;
        wr_cyc.delete();
        vblank = 1'b1;
        wait_nwr(base + 4, 10);
        idle(3);
        chk("t6_count", nwr, base + 4);
        chk("t6_busy", nbusy, 4);
        chk("t6_consec", wr_cyc[3] - wr_cyc[0], 3);
        vblank = 1'b0;

        // random traffic with toggling vblank
        repeat (150) begin
            @(negedge clk);
            vblank = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) != 0)
                push_rand($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        vblank = 1'b1;
        idle(3 * DEPTH);
        chk("drain_all", exp_q.size(), 0);
        vblank = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
